// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared types for the target-side bus cycle sequencer.
// State encoding, default timeout and the ready qualifier.
package bus_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    BC_IDLE   = 3'd0,
    BC_DECODE = 3'd1,
    BC_WAIT   = 3'd2,
    BC_DATA   = 3'd3,
    BC_TURN   = 3'd4
  } bc_state_e;

  localparam int BC_TIMEOUT = 16;

  typedef struct packed {
    logic devsel_n;
    logic trdy_n;
    logic wr_stb;
    logic rd_stb;
    logic busy;
    logic timeout_err;
  } bc_out_t;

  localparam bc_out_t BC_OUT_RST = '{
    devsel_n:    1'b1,
    trdy_n:      1'b1,
    wr_stb:      1'b0,
    rd_stb:      1'b0,
    busy:        1'b0,
    timeout_err: 1'b0
  };

  // A resource only blocks when the addressed
  // register actually depends on it.
  function automatic logic bc_ready_ok(
    input logic need_dac,
    input logic need_adc,
    input logic dac_ready,
    input logic adc_ready
  );
    return !(need_dac && !dac_ready) &&
           !(need_adc && !adc_ready);
  endfunction

  function automatic logic [7:0] bc_sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Bus-side bundle between the initiator/decoder and the sequencer.
// master: bus/decoder side; slave: cycle sequencer.
interface bus_cycle_ctrl_if;

  logic valid_pci;
  logic a_d;
  logic wr;
  logic sel_hit;
  logic need_dac;
  logic need_adc;
  logic dac_ready;
  logic adc_ready;

  logic devsel_;
  logic trdy_;
  logic wr_stb;
  logic rd_stb;
  logic busy;
  logic timeout_err;

  modport master (
    output valid_pci,
    output a_d,
    output wr,
    output sel_hit,
    output need_dac,
    output need_adc,
    output dac_ready,
    output adc_ready,
    input  devsel_,
    input  trdy_,
    input  wr_stb,
    input  rd_stb,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  valid_pci,
    input  a_d,
    input  wr,
    input  sel_hit,
    input  need_dac,
    input  need_adc,
    input  dac_ready,
    input  adc_ready,
    output devsel_,
    output trdy_,
    output wr_stb,
    output rd_stb,
    output busy,
    output timeout_err
  );

endinterface

// File: rtl/bus_cycle_ctrl.sv
// Target bus cycle sequencer: decode, wait states, strobes, timeout.
// Ports: clk, rst_ (sync active-low), bus (slave modport).
module bus_cycle_ctrl
  import bus_cycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = BC_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_,
  bus_cycle_ctrl_if.slave bus
);

  localparam logic [7:0] WLIM = 8'(TIMEOUT - 1);

  bc_state_e  state_q, state_d;
  logic       wr_q, wr_d;
  logic       ndac_q, ndac_d;
  logic       nadc_q, nadc_d;
  logic [7:0] wcnt_q, wcnt_d;
  bc_out_t    out_q, out_d;
  logic       err_d;
  logic       rdy_ok;

  assign rdy_ok = bc_ready_ok(ndac_q, nadc_q,
                              bus.dac_ready,
                              bus.adc_ready);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= BC_IDLE;
      wr_q    <= 1'b0;
      ndac_q  <= 1'b0;
      nadc_q  <= 1'b0;
      wcnt_q  <= 8'd0;
      out_q   <= BC_OUT_RST;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ndac_q  <= ndac_d;
      nadc_q  <= nadc_d;
      wcnt_q  <= wcnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    ndac_d  = ndac_q;
    nadc_d  = nadc_q;
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      BC_IDLE: begin
        if (bus.valid_pci && bus.a_d) begin
          wr_d    = bus.wr;
          state_d = BC_DECODE;
        end
      end
      BC_DECODE: begin
        if (bus.sel_hit) begin
          ndac_d  = bus.need_dac;
          nadc_d  = bus.need_adc;
          wcnt_d  = 8'd0;
          state_d = BC_WAIT;
        end else begin
          state_d = BC_IDLE;
        end
      end
      BC_WAIT: begin
        // Abandon beats new-address error,
        // which beats a ready data phase.
        if (!bus.valid_pci) begin
          state_d = BC_TURN;
        end else if (bus.a_d) begin
          state_d = BC_TURN;
          err_d   = 1'b1;
        end else if (rdy_ok) begin
          state_d = BC_DATA;
        end else if (wcnt_q == WLIM) begin
          state_d = BC_TURN;
          err_d   = 1'b1;
        end else begin
          wcnt_d = bc_sat_inc(wcnt_q);
        end
      end
      BC_DATA: state_d = BC_TURN;
      BC_TURN: state_d = BC_IDLE;
      default: state_d = BC_IDLE;
    endcase
  end

  // Outputs are registered from the next
  // state so they line up with it.
  always_comb begin
    out_d             = BC_OUT_RST;
    out_d.devsel_n    = !(state_d == BC_WAIT ||
                          state_d == BC_DATA);
    out_d.trdy_n      = (state_d != BC_DATA);
    out_d.wr_stb      = (state_d == BC_DATA) && wr_q;
    out_d.rd_stb      = (state_d == BC_DATA) && !wr_q;
    out_d.busy        = (state_d != BC_IDLE);
    out_d.timeout_err = err_d;
  end

  assign bus.devsel_     = out_q.devsel_n;
  assign bus.trdy_       = out_q.trdy_n;
  assign bus.wr_stb      = out_q.wr_stb;
  assign bus.rd_stb      = out_q.rd_stb;
  assign bus.busy        = out_q.busy;
  assign bus.timeout_err = out_q.timeout_err;

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Target-side bus cycle sequencer for the local PCI-style bus of the board controller. It watches address/data phases, uses the registered address decoder's select hit, and drives `devsel_`. It inserts wait states until the addressed DAC or ADC resource reports ready, then issues one-cycle read/write strobes to the register blocks. Cycles that never reach a data phase are terminated by a timeout.

## Interface
- `TIMEOUT`, 16: maximum wait-state cycles before forced termination (range 2..255).
- `clk` in 1: system clock, all logic on rising edge.
- `rst_` in 1: reset, synchronous, active-low.
- `valid_pci` in 1: bus phase valid qualifier.
- `a_d` in 1: 1 = address phase, 0 = data phase (qualified by `valid_pci`).
- `wr` in 1: transfer direction, sampled at address phase; 1 = write.
- `sel_hit` in 1: OR of all decoder selects; valid the cycle after the address phase.
- `need_dac` in 1: addressed register requires `dac_ready` (from decoder, same timing as `sel_hit`).
- `need_adc` in 1: addressed register requires `adc_ready`.
- `dac_ready` in 1: DAC interface idle.
- `adc_ready` in 1: ADC interface idle.
- `devsel_` out 1: device select, active-low. It also holds the decoder address register.
- `trdy_` out 1: target ready, active-low, one cycle per transfer.
- `wr_stb` out 1: one-cycle write strobe to register blocks.
- `rd_stb` out 1: one-cycle read-capture strobe.
- `busy` out 1: high in any state except IDLE.
- `timeout_err` out 1: one-cycle pulse on forced termination.

## Operation
- States: IDLE, DECODE, WAIT, DATA, TURN.
- IDLE: on `valid_pci & a_d`, latch `wr` into `wr_q` and go to DECODE.
- DECODE: the decoder address is now registered.
  - `!sel_hit`: go to IDLE. `devsel_` never asserts (master abort by the initiator).
  - `sel_hit`: latch `need_dac`/`need_adc` into `need_q`, drive `devsel_` low from the next cycle, clear `wcnt`, go to WAIT.
- WAIT: `ready_ok = !(need_dac_q & !dac_ready) & !(need_adc_q & !adc_ready)`. Evaluate in priority order:
  - `!valid_pci`: go to TURN (initiator abandoned the cycle; no strobe, no error).
  - `valid_pci & a_d`: go to TURN. A new address while selected is a protocol error and raises `timeout_err`.
  - `valid_pci & !a_d & ready_ok`: go to DATA.
  - otherwise `wcnt++`. At `wcnt == TIMEOUT-1` go to TURN and raise `timeout_err`.
- DATA: `trdy_` = 0. Assert `wr_stb` if `wr_q`, else `rd_stb`. Exactly one cycle, then TURN.
- TURN: `devsel_` = 1, `trdy_` = 1 for one cycle, then IDLE.
  - An address phase arriving in TURN is ignored; the initiator must re-issue it.
- `wcnt` is 8-bit unsigned, saturates and never wraps; compared against `TIMEOUT-1`.
- Ready inputs are sampled only in WAIT. Ready dropping after DATA has no effect.

## Timing
- All outputs are registered. Reset values: `devsel_`=1, `trdy_`=1, `wr_stb`=0, `rd_stb`=0, `busy`=0, `timeout_err`=0, state=IDLE, `wcnt`=0.
- Fastest cycle, address phase at cycle 0 with resources ready:
  - DECODE in cycle 1.
  - `devsel_` low in cycle 2 (WAIT), data phase present.
  - `trdy_` low and strobe in cycle 3.
  - `devsel_` high in cycle 4.
  - Back-to-back address accepted in cycle 5.
- Each cycle of not-ready adds one wait state between `devsel_` fall and `trdy_` fall.
- Timeout: `timeout_err` pulses in the TURN cycle; `devsel_` rises in that same cycle.
- `rst_` low mid-cycle: all outputs return to reset values on the next edge; no strobe is issued.

## Structure
- Shared package (`g_define.vh`): state encodings `BC_IDLE`..`BC_TURN` (3-bit) and the default `BC_TIMEOUT`.
- Single module; no sub-module needed. The wait counter stays inline.
- Instantiated beside the address decoder. `sel_hit` and `need_*` are produced by the decoder from its registered address.

## Test plan
- Write, both ready, address then data: `devsel_` low in cycles 2–3, `trdy_` low and `wr_stb` in cycle 3, idle by cycle 5. `rd_stb` stays 0.
- Read with `need_adc`=1 and `adc_ready` low for 5 cycles: exactly 5 wait states, then `rd_stb` one cycle with `trdy_` low.
- Unmapped address (`sel_hit`=0): `devsel_` stays 1 and there are no strobes; `busy` is high for 1 cycle only.
- `TIMEOUT`=4 with `dac_ready` stuck low: `timeout_err` pulses 4 cycles after `devsel_` falls, `devsel_` rises in that same cycle, and there is no strobe.
- `valid_pci` dropped in WAIT: TURN next cycle, no `timeout_err`, no strobe. A new address phase in TURN is ignored; a re-issue in IDLE is accepted.
- `rst_` asserted in WAIT with `devsel_` low: all outputs return to reset values on the next edge and `wcnt`=0.
